capture_mem_ctrl: RTL and testbench



---
 rtl/capture_pkg.sv | 15 +
 rtl/capture_skid_fifo.sv | 62 ++++++
 rtl/capture_mem_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_capture_mem_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/capture_pkg.sv
// Shared types and constants for the capture SRAM sequencer and its readout skid buffer.
package capture_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        FILL = 3'd1,
        POST = 3'd2,
        DONE = 3'd3,
        READ = 3'd4
    } state_t;

    localparam int SKID_DEPTH = 3;
    localparam int MEM_RD_LAT = 2;

endpackage

// File: rtl/capture_skid_fifo.sv
// Small skid FIFO that absorbs SRAM read data while the readout consumer stalls.
module capture_skid_fifo
    import capture_pkg::*;
#(
    parameter int WIDTH = 10
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_flush,
    input  logic                             i_push,
    input  logic [WIDTH-1:0]                 i_data,
    input  logic                             i_pop,
    output logic [WIDTH-1:0]                 o_data,
    output logic                             o_vld,
    output logic [$clog2(SKID_DEPTH+1)-1:0]  o_count
);

    localparam int PTR_W = $clog2(SKID_DEPTH);
    localparam int CNT_W = $clog2(SKID_DEPTH + 1);

    logic [WIDTH-1:0] r_mem [SKID_DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_push = i_push && (r_count != CNT_W'(SKID_DEPTH));
    assign w_pop  = i_pop && (r_count != '0);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= next_ptr(r_tail);
            if (w_pop)  r_head <= next_ptr(r_head);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: storage is not reset; r_count alone decides which entries are live, and
    // non-blocking writes keep the push ordered against the same-edge head update.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_tail] <= i_data;
    end

    assign o_data  = r_mem[r_head];
    assign o_vld   = (r_count != '0);
    assign o_count = r_count;

endmodule

// File: rtl/capture_mem_ctrl.sv
// Capture sequencer: circular pre-trigger write into the SRAM, post-trigger count, then
// oldest-first readout on a valid/ready stream through a skid FIFO.
module capture_mem_ctrl
    import capture_pkg::*;
#(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 9
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  arm,
    input  logic                  abort,
    input  logic                  trig,
    input  logic [ADDR_WIDTH-1:0] cfg_post_len,
    input  logic                  samp_vld,
    input  logic [DATA_WIDTH-1:0] samp_data,
    input  logic                  rd_start,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic                  wrapped,
    output logic [ADDR_WIDTH-1:0] trig_addr,
    output logic                  mem_ceb,
    output logic                  mem_web,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic [DATA_WIDTH-1:0] mem_d,
    input  logic [DATA_WIDTH-1:0] mem_q
);

    localparam int DEPTH  = 2 ** ADDR_WIDTH;
    localparam int RD_W   = ADDR_WIDTH + 1;
    localparam int CNT_W  = $clog2(SKID_DEPTH + 1);
    localparam int OCC_W  = $clog2(SKID_DEPTH + MEM_RD_LAT + 1);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [RD_W-1:0]       r_rd_cnt;
    logic [ADDR_WIDTH-1:0] r_post_cnt;
    logic [ADDR_WIDTH-1:0] r_trig_addr;
    logic                  r_wrapped;
    logic                  r_mem_ceb;
    logic                  r_mem_web;
    logic [ADDR_WIDTH-1:0] r_mem_a;
    logic [DATA_WIDTH-1:0] r_mem_d;
    logic [MEM_RD_LAT-1:0] r_pipe_vld;
    logic [MEM_RD_LAT-1:0] r_pipe_last;

    logic                  w_sample_wr;
    logic                  w_read;
    logic                  w_pop;
    logic                  w_last_xfer;
    logic                  w_fifo_vld;
    logic [DATA_WIDTH:0]   w_fifo_dout;
    logic [CNT_W-1:0]      w_fifo_cnt;
    logic [OCC_W-1:0]      w_occ;

    assign w_sample_wr = samp_vld && !abort && (r_state == FILL || r_state == POST);
    assign w_pop       = w_fifo_vld && out_rdy;
    assign w_last_xfer = w_pop && w_fifo_dout[DATA_WIDTH];

    // Slots committed after this cycle's pop; the freed slot lets a new read issue
    // immediately, which is what keeps one beat per cycle under continuous ready.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_occ = OCC_W'(w_fifo_cnt) - OCC_W'(w_pop);
        for (int i = 0; i < MEM_RD_LAT; i++) begin
            w_occ = w_occ + OCC_W'(r_pipe_vld[i]);
        end
    end

    assign w_read = (r_state == READ) && !abort
                 && (r_rd_cnt != RD_W'(DEPTH))
                 && (w_occ < OCC_W'(SKID_DEPTH));

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_rd_cnt    <= '0;
            r_post_cnt  <= '0;
            r_trig_addr <= '0;
            r_wrapped   <= 1'b0;
            r_mem_ceb   <= 1'b1;
            r_mem_web   <= 1'b1;
            r_mem_a     <= '0;
            r_mem_d     <= '0;
            r_pipe_vld  <= '0;
            r_pipe_last <= '0;
        end else if (abort) begin
            r_state    <= IDLE;
            r_mem_ceb  <= 1'b1;
            r_mem_web  <= 1'b1;
            r_pipe_vld <= '0;
        end else begin
            r_mem_ceb   <= 1'b1;
            r_mem_web   <= 1'b1;
            r_pipe_vld  <= {r_pipe_vld[MEM_RD_LAT-2:0], w_read};
            r_pipe_last <= {r_pipe_last[MEM_RD_LAT-2:0],
                            w_read && (r_rd_cnt == RD_W'(DEPTH - 1))};

            if (w_sample_wr) begin
                r_mem_ceb <= 1'b0;
                r_mem_web <= 1'b0;
                r_mem_a   <= r_wr_ptr;
                r_mem_d   <= samp_data;
                r_wr_ptr  <= r_wr_ptr + 1'b1;
                // Any wrap means every location now holds a real sample.
                if (r_wr_ptr == ADDR_WIDTH'(DEPTH - 1)) r_wrapped <= 1'b1;
            end

            if (w_read) begin
                r_mem_ceb <= 1'b0;
                r_mem_a   <= r_rd_ptr;
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_rd_cnt  <= r_rd_cnt + 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (arm) begin
                        r_wr_ptr  <= '0;
                        r_wrapped <= 1'b0;
                        r_state   <= FILL;
                    end
                end
                FILL: begin
                    if (trig) begin
                        r_trig_addr <= r_wr_ptr;
                        if (!samp_vld) begin
                            r_post_cnt <= cfg_post_len;
                            r_state    <= POST;
                        end else if (cfg_post_len == '0) begin
                            r_state <= DONE;
                        end else begin
                            r_post_cnt <= cfg_post_len - 1'b1;
                            r_state    <= POST;
                        end
                    end
                end
                POST: begin
                    if (samp_vld) begin
                        if (r_post_cnt == '0) r_state <= DONE;
                        else                  r_post_cnt <= r_post_cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (rd_start) begin
                        r_rd_ptr <= r_wr_ptr;
                        r_rd_cnt <= '0;
                        r_state  <= READ;
                    end
                end
                READ: begin
                    if (w_last_xfer) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    capture_skid_fifo #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_skid (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_flush (abort),
        .i_push  (r_pipe_vld[MEM_RD_LAT-1]),
        .i_data  ({r_pipe_last[MEM_RD_LAT-1], mem_q}),
        .i_pop   (w_pop),
        .o_data  (w_fifo_dout),
        .o_vld   (w_fifo_vld),
        .o_count (w_fifo_cnt)
    );

    assign out_vld   = w_fifo_vld;
    assign out_data  = w_fifo_dout[DATA_WIDTH-1:0];
    assign out_last  = w_fifo_vld && w_fifo_dout[DATA_WIDTH];
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign wrapped   = r_wrapped;
    assign trig_addr = r_trig_addr;
    assign mem_ceb   = r_mem_ceb;
    assign mem_web   = r_mem_web;
    assign mem_a     = r_mem_a;
    assign mem_d     = r_mem_d;

endmodule

// File: tb/tb_capture_mem_ctrl.sv
// Directed bench for capture_mem_ctrl at DEPTH=16 with a 1-cycle-latency SRAM model.
module tb_capture_mem_ctrl;

    localparam int AW = 4;
    localparam int DW = 9;

    logic          CLK;
    logic          RST;
    logic          arm;
    logic          abort;
    logic          trig;
    logic [AW-1:0] cfg_post_len;
    logic          samp_vld;
    logic [DW-1:0] samp_data;
    logic          rd_start;
    logic          out_vld;
    logic          out_rdy;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          done;
    logic          wrapped;
    logic [AW-1:0] trig_addr;
    logic          mem_ceb;
    logic          mem_web;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_d;
    logic [DW-1:0] mem_q;

    logic [DW-1:0] sram [16];

    int n_checks;
    int n_fail;
    int beat;
    int cyc;
    int writes;
    int rd_cycles;

    capture_mem_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .arm          (arm),
        .abort        (abort),
        .trig         (trig),
        .cfg_post_len (cfg_post_len),
        .samp_vld     (samp_vld),
        .samp_data    (samp_data),
        .rd_start     (rd_start),
        .out_vld      (out_vld),
        .out_rdy      (out_rdy),
        .out_data     (out_data),
        .out_last     (out_last),
        .busy         (busy),
        .done         (done),
        .wrapped      (wrapped),
        .trig_addr    (trig_addr),
        .mem_ceb      (mem_ceb),
        .mem_web      (mem_web),
        .mem_a        (mem_a),
        .mem_d        (mem_d),
        .mem_q        (mem_q)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) begin
        if (!mem_ceb && !mem_web) sram[mem_a] <= mem_d;
        if (!mem_ceb &&  mem_web) mem_q <= sram[mem_a];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample(input logic [DW-1:0] d, input logic t);
        samp_vld  = 1'b1;
        samp_data = d;
        trig      = t;
        tick();
        samp_vld  = 1'b0;
        trig      = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ceb"},      mem_ceb,   1);
        check({tag, "_web"},      mem_web,   1);
        check({tag, "_a"},        mem_a,     0);
        check({tag, "_d"},        mem_d,     0);
        check({tag, "_vld"},      out_vld,   0);
        check({tag, "_last"},     out_last,  0);
        check({tag, "_done"},     done,      0);
        check({tag, "_busy"},     busy,      0);
        check({tag, "_wrapped"},  wrapped,   0);
        check({tag, "_trigaddr"}, trig_addr, 0);
    endtask

    // 20 pre-trigger samples 0x100..0x113, lone trig, 4 post samples 0x114..0x117.
    task automatic fill_wrap();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        cfg_post_len = 4'd3;
        for (int i = 0; i < 20; i++) sample(9'h100 + 9'(i), 1'b0);
        trig = 1'b1;
        tick();
        trig = 1'b0;
        for (int i = 0; i < 4; i++) sample(9'h114 + 9'(i), 1'b0);
    endtask

    // Beats at index >= first_chk must equal base + (index - first_chk).
    task automatic readout(input logic [3:0] rdy_pat, input int first_chk,
                           input logic [DW-1:0] base, input string tag, output int cycles);
        int            nbeat;
        int            strobes;
        int            max_out;
        logic          stalled;
        logic          hold_ok;
        logic [DW-1:0] held;
        nbeat   = 0;
        strobes = 0;
        max_out = 0;
        stalled = 1'b0;
        hold_ok = 1'b1;
        held    = '0;
        cycles  = 0;
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        while (nbeat < 16 && cycles < 400) begin
            out_rdy = rdy_pat[cycles % 4];
            if (!mem_ceb && mem_web) strobes++;
            if (strobes - nbeat > max_out) max_out = strobes - nbeat;
            if (stalled && (!out_vld || out_data !== held)) hold_ok = 1'b0;
            stalled = out_vld && !out_rdy;
            held    = out_data;
            if (out_vld && out_rdy) begin
                if (nbeat >= first_chk)
                    check($sformatf("%s_beat%0d", tag, nbeat), out_data,
                          base + 9'(nbeat - first_chk));
                check($sformatf("%s_last%0d", tag, nbeat), out_last, (nbeat == 15));
                nbeat++;
            end
            tick();
            cycles++;
        end
        out_rdy = 1'b0;
        check({tag, "_beats"},       nbeat,              16);
        check({tag, "_strobes"},     strobes,            16);
        check({tag, "_outstanding"}, (max_out <= 3),     1);
        check({tag, "_hold"},        hold_ok,            1);
        check({tag, "_idle"},        busy,               0);
        check({tag, "_vld_after"},   out_vld,            0);
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        RST          = 1'b1;
        arm          = 1'b0;
        abort        = 1'b0;
        trig         = 1'b0;
        cfg_post_len = '0;
        samp_vld     = 1'b0;
        samp_data    = '0;
        rd_start     = 1'b0;
        out_rdy      = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");
        RST = 1'b0;

        // Trigger while idle does nothing.
        trig = 1'b1;
        tick();
        trig = 1'b0;
        check("idle_trig_busy", busy, 0);
        check("idle_trig_ceb",  mem_ceb, 1);

        // No-wrap capture: trig_addr 5, samples at addresses 0..7.
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("arm_busy", busy, 1);
        sample(9'h001, 1'b0);
        check("wr_ceb", mem_ceb, 0);
        check("wr_web", mem_web, 0);
        check("wr_a",   mem_a,   0);
        check("wr_d",   mem_d,   9'h001);
        for (int i = 2; i <= 5; i++) sample(9'(i), 1'b0);
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        check("fill_rdstart_done", done, 0);
        check("fill_rdstart_busy", busy, 1);
        check("fill_rdstart_ceb",  mem_ceb, 1);
        cfg_post_len = 4'd2;
        sample(9'h006, 1'b1);
        check("nw_trig_addr", trig_addr, 5);
        check("nw_trig_wr_a", mem_a, 5);
        sample(9'h007, 1'b0);
        check("nw_not_done", done, 0);
        sample(9'h008, 1'b0);
        check("nw_done",    done,    1);
        check("nw_wrapped", wrapped, 0);
        check("nw_last_a",  mem_a,   7);
        tick();
        check("done_sram_idle", mem_ceb, 1);
        check("done_no_vld",    out_vld, 0);
        // Readout starts at wr_ptr=8, so addresses 0..7 arrive as beats 8..15.
        readout(4'b1111, 8, 9'h001, "nw", rd_cycles);
        check("nw_throughput", rd_cycles, 19);

        // Wrap capture, continuous readout.
        arm = 1'b1;
        tick();
        arm = 1'b0;
        cfg_post_len = 4'd3;
        for (int i = 0; i < 20; i++) sample(9'h100 + 9'(i), 1'b0);
        check("wr_wrapped", wrapped, 1);
        trig = 1'b1;
        tick();
        trig = 1'b0;
        check("wr_trig_addr", trig_addr, 4);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("post_arm_busy", busy, 1);
        check("post_arm_ceb",  mem_ceb, 1);
        for (int i = 0; i < 3; i++) sample(9'h114 + 9'(i), 1'b0);
        check("wr_not_done", done, 0);
        sample(9'h117, 1'b0);
        check("wr_done", done, 1);
        readout(4'b1111, 0, 9'h108, "wrap", rd_cycles);

        // Same capture, ready pattern 1,0,0,1.
        fill_wrap();
        check("bp_done", done, 1);
        readout(4'b1001, 0, 9'h108, "bp", rd_cycles);

        // Abort while beat 7 is presented.
        fill_wrap();
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        out_rdy = 1'b1;
        beat = 0;
        cyc  = 0;
        while (!(out_vld && beat == 7) && cyc < 100) begin
            if (out_vld && out_rdy) beat++;
            tick();
            cyc++;
        end
        check("abort_reach", beat, 7);
        check("abort_beat7", out_data, 9'h10F);
        abort   = 1'b1;
        out_rdy = 1'b0;
        tick();
        abort = 1'b0;
        check("abort_vld",  out_vld, 0);
        check("abort_busy", busy,    0);
        check("abort_ceb",  mem_ceb, 1);
        tick();
        check("abort_vld2", out_vld, 0);
        check("abort_ceb2", mem_ceb, 1);

        // cfg_post_len = 0: the trigger sample is the only post write.
        arm = 1'b1;
        tick();
        arm = 1'b0;
        sample(9'h0AA, 1'b0);
        cfg_post_len = 4'd0;
        sample(9'h0AB, 1'b1);
        check("pl0_done",      done,      1);
        check("pl0_a",         mem_a,     1);
        check("pl0_trig_addr", trig_addr, 1);
        sample(9'h0AC, 1'b0);
        check("pl0_no_more_wr", mem_ceb, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("pl0_abort_busy", busy, 0);

        // cfg_post_len = 15: sixteen post writes.
        arm = 1'b1;
        tick();
        arm = 1'b0;
        cfg_post_len = 4'd15;
        writes = 0;
        for (int i = 0; i < 20; i++) begin
            sample(9'h040 + 9'(i), (i == 0));
            if (!mem_ceb && !mem_web) writes++;
            if (done) break;
        end
        check("pl15_writes", writes, 16);
        check("pl15_done",   done,   1);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // Reset during POST, then re-arm starts at address 0.
        arm = 1'b1;
        tick();
        arm = 1'b0;
        sample(9'h010, 1'b0);
        cfg_post_len = 4'd5;
        sample(9'h011, 1'b1);
        sample(9'h012, 1'b0);
        check("post_busy", busy, 1);
        RST = 1'b1;
        tick();
        check_reset_outputs("rst_post");
        RST = 1'b0;
        tick();
        check("rst_post_idle", busy, 0);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        sample(9'h055, 1'b0);
        check("rearm_a", mem_a, 0);
        check("rearm_d", mem_d, 9'h055);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
